// File: rtl/pll_lock_ctrl_if.sv
// pll_lock_ctrl_if
//   Bundles the PLL-side and system-side signals of the PLL lock controller.
//   master : the controller (samples pll_lock/restart, drives everything else)
//   slave  : the PLL / system side (drives pll_lock/restart, observes status)
//
//   pll_lock  : PLL lock output, asynchronous to the controller clock
//   restart   : single-cycle synchronous request to re-run the sequence
//   pll_reset : PLL reset pin, active high
//   sys_rst_n : downstream system reset, active low, released only in RUN
//   pll_ready : high while in RUN
//   fault     : high while in FAULT
//   retry_cnt : failed lock attempts since the last RUN or restart
//   loss_cnt  : lock-loss events seen in RUN, saturating at 255
//   state     : current controller state encoding, for debug
interface pll_lock_ctrl_if;
  logic       pll_lock;
  logic       restart;
  logic       pll_reset;
  logic       sys_rst_n;
  logic       pll_ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state;

  modport master (
    input  pll_lock, restart,
    output pll_reset, sys_rst_n, pll_ready, fault, retry_cnt, loss_cnt, state
  );

  modport slave (
    output pll_lock, restart,
    input  pll_reset, sys_rst_n, pll_ready, fault, retry_cnt, loss_cnt, state
  );
endinterface

// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl
//   PLL power-up / recovery sequencer running on the free-running reference
//   clock that also feeds the PLL. Pulses the PLL reset, waits for lock with a
//   timeout, qualifies lock as stable, then releases the system reset. Lock
//   loss in RUN re-runs the sequence; MAX_RETRY failed attempts latch FAULT.
//
//   clk   : free-running reference clock
//   rst_n : asynchronous reset, active low
//   bus   : pll_lock_ctrl_if.master (see interface header for signal list)
//
//   All status outputs are registered decodes of the next state, so they
//   change on the same edge as the state register.
module pll_lock_ctrl #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_RETRY    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  pll_lock_ctrl_if.master   bus
);

  localparam int TMR_LIMIT_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int TMR_LIMIT    = (TMR_LIMIT_AB > LOCK_STABLE) ? TMR_LIMIT_AB : LOCK_STABLE;
  localparam int TMR_W        = $clog2(TMR_LIMIT + 1);

  localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(LOCK_STABLE - 1);
  localparam logic [TMR_W-1:0] TMR_SAT      = '1;
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;

  logic lock_p0, lock_p1;
  logic lock_s;

  logic pll_reset_q, sys_rst_n_q, pll_ready_q, fault_q;

  // ---- stage p0/p1: two-flop synchroniser for the asynchronous lock ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_p0 <= 1'b0;
      lock_p1 <= 1'b0;
    end else begin
      lock_p0 <= bus.pll_lock;
      lock_p1 <= lock_p0;
    end
  end

  assign lock_s = lock_p1;

  // ---- next-state, timer and counter logic ----
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    if (bus.restart) begin
      // restart overrides every other transition and suppresses loss counting
      state_d = ST_RESET;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (timer_q == RST_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
          end else if (timer_q == TIMEOUT_LAST) begin
            retry_d = retry_q + 4'd1;
            state_d = (retry_d == RETRY_LIMIT) ? ST_FAULT : ST_RESET;
          end
        end
        ST_STABLE: begin
          // a dropout during qualification is not charged as a retry
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (timer_q == STABLE_LAST) begin
            state_d = ST_RUN;
            retry_d = '0;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d = ST_RESET;
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_RESET;
        end
      endcase
    end

    // one shared timer, cleared on every state entry (restart counts as
    // entry); it saturates in states with no limit so it never wraps
    if (bus.restart || (state_d != state_q)) begin
      timer_d = '0;
    end else if (timer_q == TMR_SAT) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TMR_W'(1);
    end
  end

  // ---- state register and registered Moore output decode ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET;
      timer_q     <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      pll_ready_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_reset_q <= (state_d == ST_RESET) || (state_d == ST_FAULT);
      sys_rst_n_q <= (state_d == ST_RUN);
      pll_ready_q <= (state_d == ST_RUN);
      fault_q     <= (state_d == ST_FAULT);
    end
  end

  assign bus.pll_reset = pll_reset_q;
  assign bus.sys_rst_n = sys_rst_n_q;
  assign bus.pll_ready = pll_ready_q;
  assign bus.fault     = fault_q;
  assign bus.retry_cnt = retry_q;
  assign bus.loss_cnt  = loss_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb_pll_lock_ctrl
//   Self-checking bench for pll_lock_ctrl with RST_CYCLES=4, LOCK_TIMEOUT=20,
//   LOCK_STABLE=8, MAX_RETRY=2. Directed scenario tasks plus a randomized
//   lock/restart run compared against a behavioural reference model.
module tb_pll_lock_ctrl;

  localparam int RST_CYCLES   = 4;
  localparam int LOCK_TIMEOUT = 20;
  localparam int LOCK_STABLE  = 8;
  localparam int MAX_RETRY    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks   = 0;
  int failures = 0;

  pll_lock_ctrl_if bus ();

  pll_lock_ctrl #(
    .RST_CYCLES  (RST_CYCLES),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .LOCK_STABLE (LOCK_STABLE),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #10 clk = ~clk;

  // ---------------- reference model ----------------
  // Phase-level model: current phase, cycles spent in it, and the counters.
  // The lock input is seen through a two-sample delay line.
  typedef struct packed {
    logic [2:0]  st;
    logic [31:0] el;
    logic [3:0]  retry;
    logic [7:0]  loss;
  } mdl_t;

  mdl_t       mdl;
  logic [1:0] lock_hist;

  function automatic mdl_t mdl_next(input mdl_t m, input logic lk, input logic rs);
    mdl_t n = m;
    bit   leave = 1'b0;
    if (rs) begin
      n.st = 3'd0; n.retry = 4'd0; leave = 1'b1;
    end else begin
      case (m.st)
        3'd0: if (m.el + 1 == RST_CYCLES) begin n.st = 3'd1; leave = 1'b1; end
        3'd1: begin
          if (lk) begin
            n.st = 3'd2; leave = 1'b1;
          end else if (m.el + 1 == LOCK_TIMEOUT) begin
            n.retry = m.retry + 4'd1;
            n.st = (int'(n.retry) == MAX_RETRY) ? 3'd4 : 3'd0;
            leave = 1'b1;
          end
        end
        3'd2: begin
          if (!lk) begin
            n.st = 3'd1; leave = 1'b1;
          end else if (m.el + 1 == LOCK_STABLE) begin
            n.st = 3'd3; n.retry = 4'd0; leave = 1'b1;
          end
        end
        3'd3: if (!lk) begin
          n.st = 3'd0; leave = 1'b1;
          n.loss = (m.loss == 8'd255) ? 8'd255 : m.loss + 8'd1;
        end
        default: ;
      endcase
    end
    n.el = leave ? 32'd0 : m.el + 32'd1;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl       <= '0;
      lock_hist <= 2'b00;
    end else begin
      mdl       <= mdl_next(mdl, lock_hist[1], bus.restart);
      lock_hist <= {lock_hist[0], bus.pll_lock};
    end
  end

  // ---------------- helpers (stimulus only) ----------------
  task automatic do_reset();
    bus.pll_lock = 1'b0;
    bus.restart  = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] target, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.state === target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.pll_lock = 1'b0;
    bus.restart  = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
    checks++;
    if (bus.pll_reset !== 1'b1 || bus.sys_rst_n !== 1'b0) begin
      failures++; $display("FAIL reset_pins got pll_reset=%b sys_rst_n=%b exp 1/0", bus.pll_reset, bus.sys_rst_n);
    end
    checks++;
    if (bus.pll_ready !== 1'b0 || bus.fault !== 1'b0 || bus.retry_cnt !== 4'd0 || bus.loss_cnt !== 8'd0) begin
      failures++; $display("FAIL reset_status got ready=%b fault=%b retry=%0d loss=%0d exp 0/0/0/0",
                           bus.pll_ready, bus.fault, bus.retry_cnt, bus.loss_cnt);
    end
  endtask

  task automatic test_nominal();
    int hi  = 0;
    int lat = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.pll_reset === 1'b1) hi++;
      else break;
    end
    checks++;
    if (hi != RST_CYCLES) begin failures++; $display("FAIL nominal_pll_reset_width got=%0d exp=%0d", hi, RST_CYCLES); end
    repeat (6) @(negedge clk);
    bus.pll_lock = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (bus.sys_rst_n === 1'b1) break;
    end
    // lock is driven on a falling edge: 2 sync + 8 stable cycles after the
    // first sampling edge lands on the 11th falling edge
    checks++;
    if (lat != 2 + LOCK_STABLE + 1) begin failures++; $display("FAIL nominal_release_latency got=%0d exp=%0d", lat, 2 + LOCK_STABLE + 1); end
    checks++;
    if (bus.state !== 3'd3 || bus.retry_cnt !== 4'd0 || bus.pll_ready !== 1'b1) begin
      failures++; $display("FAIL nominal_run got state=%0d retry=%0d ready=%b exp 3/0/1", bus.state, bus.retry_cnt, bus.pll_ready);
    end
  endtask

  task automatic test_timeout_fault();
    int perr      = 0;
    int fault_idx = -1;
    int attempt   = RST_CYCLES + LOCK_TIMEOUT;
    do_reset();
    for (int idx = 1; idx <= 2 * attempt + 1; idx++) begin
      logic       exp_rst;
      logic [3:0] exp_retry;
      @(negedge clk);
      // sample idx lies before edge idx: attempt k occupies samples
      // k*attempt+1 .. (k+1)*attempt, the first RST_CYCLES of which are reset
      exp_rst   = (idx > 2 * attempt) || (((idx - 1) % attempt) < RST_CYCLES);
      exp_retry = 4'((idx - 1) / attempt);
      if (bus.pll_reset !== exp_rst || bus.retry_cnt !== exp_retry) perr++;
      if (bus.fault === 1'b1 && fault_idx < 0) fault_idx = idx;
    end
    checks++;
    if (perr != 0) begin failures++; $display("FAIL timeout_pattern got=%0d bad samples exp=0", perr); end
    checks++;
    if (fault_idx - 1 != 2 * attempt) begin failures++; $display("FAIL timeout_fault_entry got=%0d cycles exp=%0d", fault_idx - 1, 2 * attempt); end
    repeat (5) @(negedge clk);
    checks++;
    if (bus.state !== 3'd4 || bus.fault !== 1'b1 || bus.pll_reset !== 1'b1 || bus.sys_rst_n !== 1'b0 || bus.retry_cnt !== 4'd2) begin
      failures++; $display("FAIL fault_hold got state=%0d fault=%b pll_reset=%b sys_rst_n=%b retry=%0d exp 4/1/1/0/2",
                           bus.state, bus.fault, bus.pll_reset, bus.sys_rst_n, bus.retry_cnt);
    end
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
    checks++;
    if (bus.state !== 3'd0 || bus.fault !== 1'b0 || bus.retry_cnt !== 4'd0 || bus.pll_reset !== 1'b1) begin
      failures++; $display("FAIL fault_restart got state=%0d fault=%b retry=%0d pll_reset=%b exp 0/0/0/1",
                           bus.state, bus.fault, bus.retry_cnt, bus.pll_reset);
    end
  endtask

  task automatic test_unstable();
    bit         ok;
    bit         saw_back  = 1'b0;
    int         stab_idx  = -1;
    int         run_idx   = -1;
    int         max_retry = 0;
    logic [2:0] prev;
    do_reset();
    wait_state(3'd1, 20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL unstable_wait_lock got state=%0d exp=1", bus.state); end
    prev = bus.state;
    for (int i = 0; i < 60; i++) begin
      bus.pll_lock = (i < 5) ? 1'b1 : (i < 8) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (prev == 3'd2 && bus.state == 3'd1) saw_back = 1'b1;
      if (prev != 3'd2 && bus.state == 3'd2) stab_idx = i;
      if (bus.state == 3'd3 && run_idx < 0) run_idx = i;
      if (int'(bus.retry_cnt) > max_retry) max_retry = int'(bus.retry_cnt);
      prev = bus.state;
      if (run_idx >= 0) break;
    end
    checks++;
    if (!saw_back || max_retry != 0) begin
      failures++; $display("FAIL unstable_return got back=%0d max_retry=%0d exp 1/0", saw_back, max_retry);
    end
    checks++;
    if (run_idx < 0 || run_idx - stab_idx != LOCK_STABLE) begin
      failures++; $display("FAIL unstable_qualify got=%0d exp=%0d", run_idx - stab_idx, LOCK_STABLE);
    end
  endtask

  task automatic test_lock_loss();
    bit ok;
    bus.pll_lock = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.state !== 3'd3) begin failures++; $display("FAIL loss_early got state=%0d exp=3", bus.state); end
    @(negedge clk);
    checks++;
    if (bus.state !== 3'd0 || bus.sys_rst_n !== 1'b0 || bus.pll_reset !== 1'b1 || bus.loss_cnt !== 8'd1) begin
      failures++; $display("FAIL loss_react got state=%0d sys_rst_n=%b pll_reset=%b loss=%0d exp 0/0/1/1",
                           bus.state, bus.sys_rst_n, bus.pll_reset, bus.loss_cnt);
    end
    bus.pll_lock = 1'b1;
    wait_state(3'd3, 50, ok);
    checks++;
    if (!ok || bus.loss_cnt !== 8'd1) begin
      failures++; $display("FAIL loss_rerun got state=%0d loss=%0d exp 3/1", bus.state, bus.loss_cnt);
    end
    for (int k = 0; k < 255; k++) begin
      bus.pll_lock = 1'b0;
      repeat (2) @(negedge clk);
      bus.pll_lock = 1'b1;
      wait_state(3'd3, 40, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL loss_loop_timeout got state=%0d exp=3 at event %0d", bus.state, k + 2); break; end
      if (k == 253) begin
        checks++;
        if (bus.loss_cnt !== 8'd255) begin failures++; $display("FAIL loss_255 got=%0d exp=255", bus.loss_cnt); end
      end
    end
    checks++;
    if (bus.loss_cnt !== 8'd255) begin failures++; $display("FAIL loss_saturate got=%0d exp=255", bus.loss_cnt); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    bus.pll_lock = 1'b0;
    repeat (2) @(negedge clk);
    bus.pll_lock = 1'b1;
    wait_state(3'd2, 40, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL midreset_reach_stable got state=%0d exp=2", bus.state); end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.state !== 3'd0 || bus.pll_reset !== 1'b1 || bus.sys_rst_n !== 1'b0 ||
        bus.loss_cnt !== 8'd0 || bus.retry_cnt !== 4'd0 || bus.pll_ready !== 1'b0) begin
      failures++; $display("FAIL midreset_async got state=%0d pll_reset=%b sys_rst_n=%b loss=%0d retry=%0d exp 0/1/0/0/0",
                           bus.state, bus.pll_reset, bus.sys_rst_n, bus.loss_cnt, bus.retry_cnt);
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    do_reset();
    bus.pll_lock = 1'b1;
    wait_state(3'd3, 60, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL simul_reach_run got state=%0d exp=3", bus.state); end
    bus.pll_lock = 1'b0;
    repeat (2) @(negedge clk);
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart  = 1'b0;
    bus.pll_lock = 1'b1;
    checks++;
    if (bus.state !== 3'd0 || bus.loss_cnt !== 8'd0 || bus.retry_cnt !== 4'd0) begin
      failures++; $display("FAIL simul_restart_loss got state=%0d loss=%0d retry=%0d exp 0/0/0",
                           bus.state, bus.loss_cnt, bus.retry_cnt);
    end
  endtask

  task automatic test_random();
    int   hold = 0;
    logic lv   = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic exp_rst, exp_run, exp_flt;
      @(negedge clk);
      exp_rst = (mdl.st == 3'd0) || (mdl.st == 3'd4);
      exp_run = (mdl.st == 3'd3);
      exp_flt = (mdl.st == 3'd4);
      checks++;
      if ({bus.state, bus.pll_reset, bus.sys_rst_n, bus.pll_ready, bus.fault, bus.retry_cnt, bus.loss_cnt} !==
          {mdl.st, exp_rst, exp_run, exp_run, exp_flt, mdl.retry, mdl.loss}) begin
        failures++;
        $display("FAIL random cyc=%0d got st=%0d rst=%b srn=%b rdy=%b flt=%b retry=%0d loss=%0d exp st=%0d rst=%b srn=%b rdy=%b flt=%b retry=%0d loss=%0d",
                 cyc, bus.state, bus.pll_reset, bus.sys_rst_n, bus.pll_ready, bus.fault, bus.retry_cnt, bus.loss_cnt,
                 mdl.st, exp_rst, exp_run, exp_run, exp_flt, mdl.retry, mdl.loss);
      end
      if (hold == 0) begin
        lv = ~lv;
        if (lv) hold = int'($urandom_range(1, 40));
        else    hold = ($urandom_range(0, 3) == 0) ? 60 : int'($urandom_range(1, 26));
      end
      hold--;
      bus.pll_lock = lv;
      bus.restart  = ($urandom_range(0, 99) == 0);
    end
    bus.restart = 1'b0;
  endtask

  initial begin
    bus.pll_lock = 1'b0;
    bus.restart  = 1'b0;
    test_reset();
    test_nominal();
    test_timeout_fault();
    test_unstable();
    test_lock_loss();
    test_mid_reset();
    test_simultaneous();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
